// File: rtl/rv_width_downsizer.sv
// Ready/valid width downsizer: serializes one IN_WIDTH word into up to RATIO
// OUT_WIDTH beats, LSB-first, with a per-word beat count taken from in_len.
module rv_width_downsizer #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [IN_WIDTH-1:0]                         in_data,
    input  logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0]       in_len,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [OUT_WIDTH-1:0]                        out_data,
    output logic                                        out_last,
    output logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0]       beat_idx
);

    localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned CNT_W = $clog2(RATIO);

    // Reject word/beat widths that do not split into at least two whole beats.
    generate
        if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_param_check
            $error("rv_width_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     idx_q, idx_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and handshake outputs; everything forced quiet while reset is high.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        len_d     = len_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        hold_d  = in_data;
                        len_d   = in_len;
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    out_valid = 1'b1;
                    out_data  = hold_q[OUT_WIDTH-1:0];
                    out_last  = (idx_q == len_q);
                    in_ready  = out_ready & out_last;
                    if (out_ready) begin
                        if (!out_last) begin
                            hold_d = hold_q >> OUT_WIDTH;
                            idx_d  = idx_q + CNT_W'(1);
                        end else if (in_valid) begin
                            // Back-to-back word: reload without a bubble.
                            hold_d = in_data;
                            len_d  = in_len;
                            idx_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign beat_idx = idx_q;

endmodule

// File: tb/tb_rv_width_downsizer.sv
// Bench for rv_width_downsizer (32 -> 8): directed cycle checks plus a
// scoreboard that predicts every beat from each accepted word.
module tb_rv_width_downsizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_len;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  beat_idx;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] idx;
    } beat_t;

    beat_t       sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    rv_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .beat_idx  (beat_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] data, input logic [1:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            beat_t b;
            b.data = data[i*8 +: 8];
            b.last = (i == int'(len));
            b.idx  = 2'(i);
            sb_q.push_back(b);
        end
    endtask

    // Scoreboard: predict beats on word acceptance, compare on beat acceptance.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready",  32'(in_ready),  32'd0);
            chk("rst_out_last",  32'(out_last),  32'd0);
            chk("rst_out_data",  32'(out_data),  32'd0);
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.data));
                    chk("sb_last", 32'(out_last), 32'(e.last));
                    chk("sb_idx",  32'(beat_idx), 32'(e.idx));
                end
            end
            if (in_valid && in_ready) push_word(in_data, in_len);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic send_one(input logic [31:0] data, input logic [1:0] len);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = data;
        in_len   = len;
        @(negedge clk);
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_beats(input string tag, input logic [31:0] data, input logic [1:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"},  32'(out_data),  32'(data[i*8 +: 8]));
            chk({tag, "_last"},  32'(out_last),  32'(i == int'(len)));
            chk({tag, "_idx"},   32'(beat_idx),  32'(i));
            chk({tag, "_rdy"},   32'(in_ready),  32'(i == int'(len)));
            @(posedge clk); #1;
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"},  32'(out_data),  32'd0);
        chk({tag, "_rdy"},   32'(in_ready),  32'd1);
    endtask

    initial begin
        logic acc_prev;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        out_ready = 1'b1;

        // Two reset cycles, then in_ready must rise.
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        expect_idle("post_reset");

        // Single full word.
        send_one(32'hDDCC_BBAA, 2'd3);
        expect_beats("full", 32'hDDCC_BBAA, 2'd3);
        expect_idle("full_idle");

        // Two words back-to-back: eight beats with no bubble.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 32'h4433_2211;
        in_len   = 2'd3;
        @(posedge clk); #1;
        in_data  = 32'h8877_6655;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_data",  32'(out_data),  32'(8'h11 + 8'(i * 8'h11)));
            chk("b2b_rdy",   32'(in_ready),  32'((i == 3) || (i == 7)));
            @(posedge clk); #1;
            if (i == 3) in_valid = 1'b0;
        end
        expect_idle("b2b_idle");

        // Backpressure while the second beat is shown.
        send_one(32'hDDCC_BBAA, 2'd3);
        @(negedge clk);
        chk("stall_first", 32'(out_data), 32'hAA);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data",  32'(out_data),  32'hBB);
            chk("stall_idx",   32'(beat_idx),  32'd1);
            chk("stall_last",  32'(out_last),  32'd0);
            chk("stall_rdy",   32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_bb", 32'(out_data), 32'hBB);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resume_cc", 32'(out_data), 32'hCC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resume_dd",   32'(out_data), 32'hDD);
        chk("resume_last", 32'(out_last), 32'd1);
        @(posedge clk); #1;
        expect_idle("stall_idle");

        // Partial word: only two beats leave.
        send_one(32'h1122_3344, 2'd1);
        expect_beats("part", 32'h1122_3344, 2'd1);
        expect_idle("part_idle0");
        expect_idle("part_idle1");

        // Reset in the middle of a word discards the remainder.
        send_one(32'hDDCC_BBAA, 2'd3);
        @(negedge clk);
        chk("mid_aa", 32'(out_data), 32'hAA);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_bb", 32'(out_data), 32'hBB);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        expect_idle("mid_after");
        send_one(32'h5566_7788, 2'd3);
        expect_beats("mid_next", 32'h5566_7788, 2'd3);

        // Random traffic with random backpressure, checked by the scoreboard.
        acc_prev = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (!in_valid || acc_prev) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = $urandom;
                    in_len   = 2'($urandom_range(0, 3));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc_prev = in_valid && in_ready;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) break;
        end
        chk("drain_queue", 32'(sb_q.size()), 32'd0);
        chk("drain_valid", 32'(out_valid),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
